// File: rtl/button_mux_ctrl.sv
// Front-panel select controller: debounced, priority-encoded buttons drive the
// mux select; a switch rising edge emits a fixed write code, then locks.
module button_mux_ctrl #(
  parameter int N_BUTTONS    = 5,
  parameter int SEL_W        = 3,
  parameter int DEBOUNCE     = 4,
  parameter int WRITE_CODE   = 5,
  parameter int WRITE_CYCLES = 1,
  parameter int STICKY       = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_buttons,
  input  logic                 i_switch,
  output logic [SEL_W-1:0]     o_out,
  output logic                 o_write_pulse,
  output logic                 o_locked
);

  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int WCNT_W = $clog2(WRITE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_LOCKED} state_t;

  state_t               r_state;
  logic [N_BUTTONS-1:0] r_deb;
  logic [CNT_W-1:0]     r_cnt [N_BUTTONS];
  logic                 r_switch_q;
  logic [WCNT_W-1:0]    r_wcnt;
  logic [SEL_W-1:0]     r_sticky;

  logic [SEL_W-1:0]     w_code;
  logic [SEL_W-1:0]     w_idle_code;
  logic                 w_rise;

  // Highest-index pressed button wins.
  always_comb begin
    w_code = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (r_deb[i]) w_code = SEL_W'(i + 1);
    end
  end

  assign w_idle_code = (STICKY != 0 && w_code == '0) ? r_sticky : w_code;
  assign w_rise      = i_switch & ~r_switch_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_deb <= '0;
      for (int i = 0; i < N_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (i_buttons[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          r_deb[i] <= i_buttons[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_switch_q    <= 1'b0;
      r_wcnt        <= '0;
      r_sticky      <= '0;
      o_out         <= '0;
      o_write_pulse <= 1'b0;
      o_locked      <= 1'b0;
    end else begin
      r_switch_q <= i_switch;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state       <= S_WRITE;
            r_wcnt        <= WCNT_W'(1);
            o_out         <= SEL_W'(WRITE_CODE);
            o_write_pulse <= 1'b1;
          end else begin
            o_out    <= w_idle_code;
            r_sticky <= w_idle_code;
          end
        end
        S_WRITE: begin
          // Rises seen here are dropped; the pulse length is fixed.
          if (r_wcnt == WCNT_W'(WRITE_CYCLES)) begin
            o_write_pulse <= 1'b0;
            if (i_switch) begin
              r_state  <= S_LOCKED;
              o_out    <= '0;
              o_locked <= 1'b1;
              r_sticky <= '0;
            end else begin
              r_state  <= S_IDLE;
              o_out    <= w_idle_code;
              r_sticky <= w_idle_code;
            end
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!i_switch) begin
            r_state  <= S_IDLE;
            o_locked <= 1'b0;
            o_out    <= w_idle_code;
            r_sticky <= w_idle_code;
          end else begin
            o_out <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_mux_ctrl.sv
// Bench for button_mux_ctrl: three configurations share stimulus; a table,
// hand sequences and a random run are checked against a behavioural model.
module tb_button_mux_ctrl;

  localparam int D     = 4;
  localparam int WCODE = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       sw;
  logic [2:0] out_a, out_b, out_c;
  logic       wp_a, wp_b, wp_c, lk_a, lk_b, lk_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_mux_ctrl dut_a (
    .i_clock(clk), .i_reset(rst), .i_buttons(btn), .i_switch(sw),
    .o_out(out_a), .o_write_pulse(wp_a), .o_locked(lk_a));

  button_mux_ctrl #(.WRITE_CYCLES(3)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_buttons(btn), .i_switch(sw),
    .o_out(out_b), .o_write_pulse(wp_b), .o_locked(lk_b));

  button_mux_ctrl #(.STICKY(1)) dut_c (
    .i_clock(clk), .i_reset(rst), .i_buttons(btn), .i_switch(sw),
    .o_out(out_c), .o_write_pulse(wp_c), .o_locked(lk_c));

  // Reference model: run lengths of raw levels, pulse time remaining, held code.
  int         wc_cfg [3] = '{1, 3, 1};
  int         st_cfg [3] = '{0, 0, 1};
  logic [4:0] m_deb, m_last;
  int         m_run  [5];
  bit         m_swq;
  int         m_mode [3];
  int         m_left [3];
  int         m_held [3];
  int         m_out  [3];
  int         m_wp   [3];
  int         m_lk   [3];

  function automatic int prio(input logic [4:0] v);
    int c = 0;
    for (int i = 0; i < 5; i++) if (v[i]) c = i + 1;
    return c;
  endfunction

  function automatic int get_out(input int k);
    case (k)
      0: return int'(out_a);
      1: return int'(out_b);
      default: return int'(out_c);
    endcase
  endfunction

  function automatic int get_wp(input int k);
    case (k)
      0: return int'(wp_a);
      1: return int'(wp_b);
      default: return int'(wp_c);
    endcase
  endfunction

  function automatic int get_lk(input int k);
    case (k)
      0: return int'(lk_a);
      1: return int'(lk_b);
      default: return int'(lk_c);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_deb = '0;
    m_last = '0;
    m_swq = 1'b0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_held[k] = 0;
      m_out[k] = 0;  m_wp[k] = 0;   m_lk[k] = 0;
    end
  endtask

  // mode: 0 idle, 1 write pulse in progress, 2 locked
  task automatic model_step(input logic [4:0] b, input logic s);
    int code;
    bit rise;
    code = prio(m_deb);
    rise = s && !m_swq;
    for (int k = 0; k < 3; k++) begin
      int iv;
      iv = (st_cfg[k] != 0 && code == 0) ? m_held[k] : code;
      if (m_mode[k] == 0) begin
        if (rise) begin
          m_mode[k] = 1; m_left[k] = wc_cfg[k]; m_out[k] = WCODE; m_wp[k] = 1;
        end else begin
          m_held[k] = iv; m_out[k] = iv;
        end
      end else if (m_mode[k] == 1) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_wp[k] = 0;
          if (s) begin
            m_mode[k] = 2; m_out[k] = 0; m_lk[k] = 1; m_held[k] = 0;
          end else begin
            m_mode[k] = 0; m_held[k] = iv; m_out[k] = iv;
          end
        end
      end else begin
        if (!s) begin
          m_mode[k] = 0; m_lk[k] = 0; m_held[k] = iv; m_out[k] = iv;
        end else begin
          m_out[k] = 0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (b[i] == m_last[i]) m_run[i]++;
      else begin
        m_run[i] = 1;
        m_last[i] = b[i];
      end
      if (b[i] != m_deb[i] && m_run[i] >= D) m_deb[i] = b[i];
    end
    m_swq = s;
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_out[%0d]", k), get_out(k), m_out[k]);
      check($sformatf("model_wp[%0d]", k), get_wp(k), m_wp[k]);
      check($sformatf("model_lk[%0d]", k), get_lk(k), m_lk[k]);
    end
  endtask

  task automatic tick(input logic [4:0] b, input logic s);
    btn = b;
    sw  = s;
    @(posedge clk);
    model_step(b, s);
    @(negedge clk);
    check_model();
  endtask

  task automatic chk(input int k, input string name, input int eo, input int ewp, input int elk);
    check($sformatf("%s_out[%0d]", name, k), get_out(k), eo);
    check($sformatf("%s_wp[%0d]", name, k), get_wp(k), ewp);
    check($sformatf("%s_lk[%0d]", name, k), get_lk(k), elk);
  endtask

  // Reset lands between edges; outputs must clear before any clock edge.
  task automatic pulse_reset_check(input string name);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk(k, name, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [4:0] b;
    logic       s;
    int         eo;
    int         ewp;
    int         elk;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [4:0] b, input logic s, input int eo,
                     input int ewp, input int elk, input int n);
    vec_t v;
    v.b = b; v.s = s; v.eo = eo; v.ewp = ewp; v.elk = elk;
    for (int i = 0; i < n; i++) vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rb;
    logic       rs;
    rst = 1'b1;
    btn = '0;
    sw  = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk(k, "reset", 0, 0, 0);
    rst = 1'b0;
    model_reset();

    // Press/release latency, glitch rejection, priority, write/lock cycle (default config)
    add(5'b00100, 1'b0, 0, 0, 0, 4);
    add(5'b00100, 1'b0, 3, 0, 0, 2);
    add(5'b00000, 1'b0, 3, 0, 0, 4);
    add(5'b00000, 1'b0, 0, 0, 0, 1);
    add(5'b00001, 1'b0, 0, 0, 0, 3);
    add(5'b00000, 1'b0, 0, 0, 0, 1);
    add(5'b01010, 1'b0, 0, 0, 0, 4);
    add(5'b01010, 1'b0, 4, 0, 0, 2);
    add(5'b00010, 1'b0, 4, 0, 0, 4);
    add(5'b00010, 1'b0, 2, 0, 0, 1);
    add(5'b00010, 1'b1, 5, 1, 0, 1);
    add(5'b00010, 1'b1, 0, 0, 1, 2);
    add(5'b00010, 1'b0, 2, 0, 0, 2);
    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].b, vt[i].s);
      chk(0, $sformatf("vec%0d", i), vt[i].eo, vt[i].ewp, vt[i].elk);
    end

    // Three-cycle pulse with switch chatter: no retrigger, exit by final switch level
    tick(5'b00010, 1'b1); chk(1, "wc3_a1", 5, 1, 0);
    tick(5'b00010, 1'b0); chk(1, "wc3_a2", 5, 1, 0);
    tick(5'b00010, 1'b1); chk(1, "wc3_a3", 5, 1, 0);
    tick(5'b00010, 1'b1); chk(1, "wc3_lock", 0, 0, 1);
    tick(5'b00010, 1'b1); chk(1, "wc3_lock2", 0, 0, 1);
    tick(5'b00010, 1'b0); chk(1, "wc3_unlock", 2, 0, 0);
    tick(5'b00010, 1'b1); chk(1, "wc3_b1", 5, 1, 0);
    tick(5'b00010, 1'b0); chk(1, "wc3_b2", 5, 1, 0);
    tick(5'b00010, 1'b1); chk(1, "wc3_b3", 5, 1, 0);
    tick(5'b00010, 1'b0); chk(1, "wc3_idle", 2, 0, 0);
    tick(5'b00010, 1'b0); chk(1, "wc3_noretrig", 2, 0, 0);

    // Sticky hold, then cleared by passing through LOCKED
    repeat (4) tick(5'b00100, 1'b0);
    chk(2, "sticky_pre", 2, 0, 0);
    tick(5'b00100, 1'b0);
    chk(2, "sticky_press", 3, 0, 0);
    repeat (5) tick(5'b00000, 1'b0);
    chk(2, "sticky_hold", 3, 0, 0);
    chk(0, "nonsticky_rel", 0, 0, 0);
    repeat (5) tick(5'b00001, 1'b0);
    chk(2, "sticky_b0", 1, 0, 0);
    repeat (5) tick(5'b00000, 1'b0);
    chk(2, "sticky_hold1", 1, 0, 0);
    tick(5'b00000, 1'b1); chk(2, "sticky_wr", 5, 1, 0);
    tick(5'b00000, 1'b1); chk(2, "sticky_lk", 0, 0, 1);
    tick(5'b00000, 1'b0); chk(2, "sticky_clr", 0, 0, 0);
    tick(5'b00000, 1'b0); chk(2, "sticky_clr2", 0, 0, 0);

    // Reset mid-pulse and mid-debounce
    tick(5'b00100, 1'b1); chk(0, "pre_rst_wr", 5, 1, 0);
    sw = 1'b0;
    pulse_reset_check("rst_pulse");
    repeat (4) tick(5'b00100, 1'b0);
    chk(0, "rst_deb4", 0, 0, 0);
    tick(5'b00100, 1'b0);
    chk(0, "rst_deb5", 3, 0, 0);
    repeat (2) tick(5'b00000, 1'b0);
    chk(0, "rel_mid", 3, 0, 0);
    btn = 5'b00100;
    pulse_reset_check("rst_deb");
    repeat (4) tick(5'b00100, 1'b0);
    chk(0, "rst2_deb4", 0, 0, 0);
    tick(5'b00100, 1'b0);
    chk(0, "rst2_deb5", 3, 0, 0);

    // Random traffic against the model
    rb = 5'b00100;
    rs = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) rb = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rs = ~rs;
      if ($urandom_range(0, 299) == 0) pulse_reset_check("rst_rand");
      tick(rb, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
